// File: rtl/lshift16_gen_reg.sv
// lshift16_gen_reg: logical left barrel shifter with a registered output.
//   OUT = A << shl, zero-filled, bits past the MSB discarded. The core is a
//   log2 mux network (shift by 1, 2, 4, 8, ...), one stage per shl bit, built
//   from an array of lshift16_stage instances. The result register loads only
//   on in_valid, so a held OUT is insensitive to A/shl while idle.
// Ports:
//   clk        rising-edge clock
//   rst_n      async active-low reset; clears OUT and out_valid
//   in_valid   A/shl valid this cycle; capture result at next edge
//   A          data operand [WIDTH-1:0]
//   shl        shift amount [SHW-1:0], unsigned
//   out_valid  OUT holds a result captured at the last edge
//   OUT        registered shift result [WIDTH-1:0]

// One mux stage: shifts by the fixed amount SH when en_i is set.
module lshift16_stage #(
  parameter int WIDTH = 16,
  parameter int SH    = 1
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);
  assign q_o = en_i ? (d_i << SH) : d_i;
endmodule

module lshift16_gen_reg #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shl,
  output logic             out_valid,
  output logic [WIDTH-1:0] OUT
);

  // stg[0] is the operand, stg[SHW] the fully shifted result.
  logic [SHW:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0]        out_d, out_q;
  logic                    vld_d, vld_q;

  assign stg[0] = A;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    lshift16_stage #(
      .WIDTH (WIDTH),
      .SH    (1 << k)
    ) u_stage (
      .d_i  (stg[k]),
      .en_i (shl[k]),
      .q_o  (stg[k+1])
    );
  end

  // Hold OUT when idle so X on shl/A cannot leak into the register.
  assign out_d = in_valid ? stg[SHW] : out_q;
  assign vld_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_lshift16_gen_reg.sv
module tb_lshift16_gen_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [3:0]  shl;
  logic        out_valid;
  logic [15:0] OUT;

  int nvec = 0;
  int nerr = 0;

  lshift16_gen_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .shl       (shl),
    .out_valid (out_valid),
    .OUT       (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [3:0]  s;
    logic        v;
    logic [15:0] eo;
    logic        ev;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [15:0] eo, input logic ev);
    nvec++;
    if (OUT !== eo || out_valid !== ev) begin
      nerr++;
      $display("FAIL %s: got OUT=%h out_valid=%b, want OUT=%h out_valid=%b",
               nm, OUT, out_valid, eo, ev);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic [15:0] a, input logic [3:0] s, input logic v);
    A = a; shl = s; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic shift truncated to 16 bits.
  function automatic logic [15:0] ref_shl(input logic [15:0] a, input int s);
    int unsigned w;
    w = (32'(a) << s) & 32'hFFFF;
    return w[15:0];
  endfunction

  logic [15:0] sweep_exp[16];
  logic [15:0] m_out;
  logic        m_vld;

  initial begin
    sweep_exp = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE0,
                  16'hFFC0, 16'hFF80, 16'hFF00, 16'hFE00, 16'hFC00, 16'hF800,
                  16'hF000, 16'hE000, 16'hC000, 16'h8000};

    tbl.push_back('{"basic_0003_sh4", 16'h0003, 4'd4,  1'b1, 16'h0030, 1'b1});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{$sformatf("sweep_ffff_sh%0d", i), 16'hFFFF, 4'(i), 1'b1, sweep_exp[i], 1'b1});
    tbl.push_back('{"a8001_sh0",      16'h8001, 4'd0,  1'b1, 16'h8001, 1'b1});
    tbl.push_back('{"a8001_sh1",      16'h8001, 4'd1,  1'b1, 16'h0002, 1'b1});
    tbl.push_back('{"a8001_sh15",     16'h8001, 4'd15, 1'b1, 16'h8000, 1'b1});
    tbl.push_back('{"a0000_sh7",      16'h0000, 4'd7,  1'b1, 16'h0000, 1'b1});
    tbl.push_back('{"a0000_sh15",     16'h0000, 4'd15, 1'b1, 16'h0000, 1'b1});
    tbl.push_back('{"a1234_sh8",      16'h1234, 4'd8,  1'b1, 16'h3400, 1'b1});
    tbl.push_back('{"hold_idle_1",    16'hFFFF, 4'd3,  1'b0, 16'h3400, 1'b0});
    tbl.push_back('{"hold_idle_2",    16'hA5A5, 4'd1,  1'b0, 16'h3400, 1'b0});
    tbl.push_back('{"a5a5a_sh15",     16'h5A5B, 4'd15, 1'b1, 16'h8000, 1'b1});

    rst_n = 1'b0; in_valid = 1'b0; A = '0; shl = '0;
    #1;
    chk("reset_initial", 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_release_idle", 16'h0000, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].a, tbl[i].s, tbl[i].v);
      chk(tbl[i].nm, tbl[i].eo, tbl[i].ev);
    end

    // X on shl while idle must leave OUT held.
    A = 16'hFFFF; shl = 4'bxxxx; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_x_shl", 16'h8000, 1'b0);

    // Mid-stream async reset drops the in-flight result.
    step(16'h00FF, 4'd4, 1'b1);
    chk("pre_reset_load", 16'h0FF0, 1'b1);
    A = 16'h1111; shl = 4'd1; in_valid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_midcycle", 16'h0000, 1'b0);
    @(posedge clk); #1;
    chk("reset_held_over_edge", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", 16'h0000, 1'b0);
    step(16'h0001, 4'd15, 1'b1);
    chk("post_reset_first", 16'h8000, 1'b1);

    // Randomized run against the reference model.
    m_out = 16'h8000;
    m_vld = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [3:0]  rs;
      logic        rv;
      ra = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      step(ra, rs, rv);
      if (rv) m_out = ref_shl(ra, int'(rs));
      m_vld = rv;
      chk($sformatf("rand_%0d_a%h_s%0d_v%0b", i, ra, rs, rv), m_out, m_vld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
